// File: rtl/fsm_core_arbiter.sv
// rtl/fsm_core_arbiter.sv - two-requester round-robin session arbiter for a shared Mealy FSM core
module fsm_core_arbiter #(
   parameter int XW      = 18,
   parameter int YW      = 39,
   parameter int TIMEOUT = 16,
   parameter int CW      = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [1:0]    i_req,
   input  logic [1:0]    i_vec_valid,
   input  logic [XW-1:0] i_vec0,
   input  logic [XW-1:0] i_vec1,
   input  logic [1:0]    i_last,
   output logic [1:0]    o_gnt,
   output logic [1:0]    o_vec_ready,
   output logic          o_rsp_valid,
   output logic          o_rsp_id,
   output logic [YW-1:0] o_rsp_y,
   output logic          o_timeout,
   output logic [CW-1:0] o_vec_count,
   output logic          o_core_rst,
   output logic          o_core_en,
   output logic [XW-1:0] o_core_x,
   input  logic [YW-1:0] i_core_y
);

   // Idle counter only needs to hold 0 .. TIMEOUT-1.
   localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CRST   = 2'd1,
      S_STREAM = 2'd2,
      S_REL    = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_owner;
   logic          r_last_owner;
   logic [TW-1:0] r_idle_cnt;
   logic [CW-1:0] r_vec_count;
   logic          r_rsp_valid;
   logic          r_rsp_id;
   logic [YW-1:0] r_rsp_y;
   logic          r_timeout;

   logic          w_owner_req;
   logic          w_owner_valid;
   logic          w_owner_last;
   logic [XW-1:0] w_owner_vec;
   logic [1:0]    w_owner_onehot;
   logic          w_pick;
   logic          w_start;
   logic          w_stream;
   logic          w_abort;
   logic          w_xfer;
   logic          w_close_last;
   logic          w_close_to;
   logic [1:0]    w_gnt;
   logic [1:0]    w_vec_ready;
   logic          w_core_crst;

   // Owner-side views of the requester inputs; the non-owner is never looked at.
   assign w_owner_req    = r_owner ? i_req[1]       : i_req[0];
   assign w_owner_valid  = r_owner ? i_vec_valid[1] : i_vec_valid[0];
   assign w_owner_last   = r_owner ? i_last[1]      : i_last[0];
   assign w_owner_vec    = r_owner ? i_vec1         : i_vec0;
   assign w_owner_onehot = r_owner ? 2'b10          : 2'b01;

   // Round-robin pick: on contention the requester that did not own last wins.
   assign w_pick  = (i_req == 2'b11) ? ~r_last_owner : i_req[1];
   assign w_start = (r_state == S_IDLE) && (i_req != 2'b00);

   // A dropped request masks ready, so abort and transfer are mutually exclusive.
   assign w_stream     = (r_state == S_STREAM);
   assign w_abort      = w_stream && !w_owner_req;
   assign w_xfer       = w_stream && w_owner_req && w_owner_valid;
   assign w_close_last = w_xfer && w_owner_last;
   assign w_close_to   = w_stream && w_owner_req && !w_owner_valid && (r_idle_cnt == TO_LAST);

   // Next-state and per-state grant/ready/core-reset decode.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt       = 2'b00;
      w_vec_ready = 2'b00;
      w_core_crst = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req != 2'b00) begin
               w_state_nxt = S_CRST;
            end
         end
         S_CRST: begin
            w_gnt       = w_owner_onehot;
            w_core_crst = 1'b1;
            w_state_nxt = S_STREAM;
         end
         S_STREAM: begin
            w_gnt = w_owner_onehot;
            if (w_owner_req) begin
               w_vec_ready = w_owner_onehot;
            end
            if (w_abort || w_close_last || w_close_to) begin
               w_state_nxt = S_REL;
            end
         end
         S_REL: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_gnt       = w_gnt;
   assign o_vec_ready = w_vec_ready;
   assign o_core_en   = w_xfer;
   assign o_core_x    = w_xfer ? w_owner_vec : '0;
   assign o_core_rst  = i_rst || w_core_crst;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_y     = r_rsp_y;
   assign o_timeout   = r_timeout;
   assign o_vec_count = r_vec_count;

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Session owner is latched at grant; last_owner is updated on release.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
      end else begin
         if (w_start) begin
            r_owner <= w_pick;
         end
         if (r_state == S_REL) begin
            r_last_owner <= r_owner;
         end
      end
   end

   // Idle counter: counts STREAM cycles since the last accepted vector.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idle_cnt <= '0;
      end else if (w_start || w_xfer) begin
         r_idle_cnt <= '0;
      end else if (w_stream && (r_idle_cnt != TO_LAST)) begin
         r_idle_cnt <= r_idle_cnt + TW'(1);
      end
   end

   // Saturating count of vectors accepted in the session.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vec_count <= '0;
      end else if (w_start) begin
         r_vec_count <= '0;
      end else if (w_xfer && (r_vec_count != {CW{1'b1}})) begin
         r_vec_count <= r_vec_count + CW'(1);
      end
   end

   // Capture the core's Mealy output for each accepted vector; one-cycle latency.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_y     <= '0;
      end else begin
         r_rsp_valid <= w_xfer;
         if (w_xfer) begin
            r_rsp_id <= r_owner;
            r_rsp_y  <= i_core_y;
         end
      end
   end

   // Timeout pulse lands in the REL cycle that the timeout close produces.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_close_to;
      end
   end

endmodule

// File: tb/tb_fsm_core_arbiter.sv
// tb/tb_fsm_core_arbiter.sv - directed self-checking bench for fsm_core_arbiter
module tb_fsm_core_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  vec_valid;
   logic [17:0] vec0;
   logic [17:0] vec1;
   logic [1:0]  last;
   logic [1:0]  gnt;
   logic [1:0]  vec_ready;
   logic        rsp_valid;
   logic        rsp_id;
   logic [38:0] rsp_y;
   logic        timeout;
   logic [15:0] vec_count;
   logic        core_rst;
   logic        core_en;
   logic [17:0] core_x;
   logic [38:0] core_y;

   int n_assert = 0;
   int n_fail   = 0;

   fsm_core_arbiter #(.XW(18), .YW(39), .TIMEOUT(16), .CW(16)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_vec_valid (vec_valid),
      .i_vec0      (vec0),
      .i_vec1      (vec1),
      .i_last      (last),
      .o_gnt       (gnt),
      .o_vec_ready (vec_ready),
      .o_rsp_valid (rsp_valid),
      .o_rsp_id    (rsp_id),
      .o_rsp_y     (rsp_y),
      .o_timeout   (timeout),
      .o_vec_count (vec_count),
      .o_core_rst  (core_rst),
      .o_core_en   (core_en),
      .o_core_x    (core_x),
      .i_core_y    (core_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in benchmark core: 3-bit step counter, Mealy output built from state and x.
   logic [2:0] core_st;
   always @(posedge clk or posedge rst) begin
      if (rst)          core_st <= 3'd0;
      else if (core_rst) core_st <= 3'd0;
      else if (core_en)  core_st <= core_st + 3'd1;
   end

   // y[17:0] = x ^ state, y35/y36 (bits 34/35) = x1&x2 in reset state, y[38:36] = state.
   always_comb begin
      core_y        = '0;
      core_y[17:0]  = core_x ^ {15'd0, core_st};
      core_y[34]    = (core_st == 3'd0) && core_x[0] && core_x[1];
      core_y[35]    = (core_st == 3'd0) && core_x[0] && core_x[1];
      core_y[38:36] = core_st;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [1:0]  exp_g;
      logic        exp_id;
      logic [17:0] exp_x;

      rst = 1'b0; req = 2'b00; vec_valid = 2'b00; vec0 = '0; vec1 = '0; last = 2'b00;
      #1 rst = 1'b1;
      #1;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_ready", vec_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 1'b0);
      chk("rst_rsp_y", rsp_y, 39'd0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_vec_count", vec_count, 16'd0);
      chk("rst_core_rst", core_rst, 1'b1);
      chk("rst_core_en", core_en, 1'b0);
      chk("rst_core_x", core_x, 18'd0);
      tick(); tick();
      rst = 1'b0;
      #1 chk("rel_core_rst", core_rst, 1'b0);
      tick();

      // Single session, requester 0, three vectors, last on the third.
      req = 2'b01;
      #1 chk("s1_idle_gnt", gnt, 2'b00);
      tick();
      #1;
      chk("s1_crst_gnt", gnt, 2'b01);
      chk("s1_crst_core_rst", core_rst, 1'b1);
      chk("s1_crst_ready", vec_ready, 2'b00);
      chk("s1_crst_core_en", core_en, 1'b0);
      tick();
      vec_valid = 2'b01; vec0 = 18'h3;
      #1;
      chk("s1_x1_ready", vec_ready, 2'b01);
      chk("s1_x1_core_en", core_en, 1'b1);
      chk("s1_x1_core_x", core_x, 18'h3);
      chk("s1_x1_core_rst", core_rst, 1'b0);
      chk("s1_x1_rsp_valid", rsp_valid, 1'b0);
      tick();
      vec0 = 18'h5;
      #1;
      chk("s1_r1_valid", rsp_valid, 1'b1);
      chk("s1_r1_id", rsp_id, 1'b0);
      chk("s1_r1_mealy_y", rsp_y, 39'h0C_0000_0003);
      tick();
      vec0 = 18'h10; last = 2'b01;
      #1;
      chk("s1_r2_valid", rsp_valid, 1'b1);
      chk("s1_r2_y", rsp_y, 39'h10_0000_0004);
      chk("s1_r2_count", vec_count, 16'd2);
      tick();
      req = 2'b00; vec_valid = 2'b00; last = 2'b00;
      #1;
      chk("s1_rel_gnt", gnt, 2'b00);
      chk("s1_rel_ready", vec_ready, 2'b00);
      chk("s1_rel_core_en", core_en, 1'b0);
      chk("s1_r3_valid", rsp_valid, 1'b1);
      chk("s1_r3_id", rsp_id, 1'b0);
      chk("s1_r3_y", rsp_y, 39'h20_0000_0012);
      chk("s1_rel_count", vec_count, 16'd3);
      chk("s1_rel_timeout", timeout, 1'b0);
      tick();

      // Round robin: both requesting, single-vector sessions; last owner was 0.
      req = 2'b11; vec_valid = 2'b11; last = 2'b11; vec0 = 18'h1; vec1 = 18'h2;
      #1;
      chk("s1_idle_rsp_valid", rsp_valid, 1'b0);
      chk("s1_idle_count", vec_count, 16'd3);
      for (int i = 0; i < 4; i++) begin
         exp_g  = (i % 2 == 0) ? 2'b10 : 2'b01;
         exp_id = (i % 2 == 0) ? 1'b1 : 1'b0;
         exp_x  = (i % 2 == 0) ? 18'h2 : 18'h1;
         chk("rr_idle_gnt", gnt, 2'b00);
         tick();
         #1;
         chk("rr_crst_gnt", gnt, exp_g);
         chk("rr_crst_core_rst", core_rst, 1'b1);
         tick();
         #1;
         chk("rr_stream_ready", vec_ready, exp_g);
         chk("rr_stream_core_en", core_en, 1'b1);
         chk("rr_stream_core_x", core_x, exp_x);
         tick();
         if (i == 3) begin
            req = 2'b00; vec_valid = 2'b00; last = 2'b00;
         end
         #1;
         chk("rr_rel_gnt", gnt, 2'b00);
         chk("rr_rel_rsp_valid", rsp_valid, 1'b1);
         chk("rr_rel_rsp_id", rsp_id, exp_id);
         chk("rr_rel_rsp_y", rsp_y, {21'd0, exp_x});
         tick();
         #1;
      end

      // Timeout: requester 1 sends one vector then idles; requester 0 waits.
      req = 2'b10;
      #1 chk("to_idle_gnt", gnt, 2'b00);
      tick();
      #1 chk("to_crst_gnt", gnt, 2'b10);
      tick();
      vec_valid = 2'b10; vec1 = 18'h7;
      #1;
      chk("to_x_core_en", core_en, 1'b1);
      chk("to_x_core_x", core_x, 18'h7);
      tick();
      vec_valid = 2'b00; req = 2'b11;
      for (int k = 0; k < 16; k++) begin
         #1;
         chk("to_wait_gnt", gnt, 2'b10);
         chk("to_wait_core_en", core_en, 1'b0);
         chk("to_wait_timeout", timeout, 1'b0);
         if (k == 0) begin
            chk("to_rsp_valid", rsp_valid, 1'b1);
            chk("to_rsp_id", rsp_id, 1'b1);
            chk("to_rsp_y", rsp_y, 39'h0C_0000_0007);
            chk("to_wait_ready", vec_ready, 2'b10);
         end
         tick();
      end
      #1;
      chk("to_rel_timeout", timeout, 1'b1);
      chk("to_rel_gnt", gnt, 2'b00);
      chk("to_rel_count", vec_count, 16'd1);
      chk("to_rel_rsp_valid", rsp_valid, 1'b0);
      tick();
      #1;
      chk("to_idle_timeout", timeout, 1'b0);
      chk("to_idle_gnt2", gnt, 2'b00);
      tick();
      #1 chk("to_next_gnt", gnt, 2'b01);
      tick();

      // Abort: owner 0 drops request while requester 1 asserts valid.
      vec_valid = 2'b10; vec1 = 18'h55;
      #1;
      chk("ab_foreign_ready", vec_ready, 2'b01);
      chk("ab_foreign_core_en", core_en, 1'b0);
      chk("ab_foreign_core_x", core_x, 18'd0);
      tick();
      req = 2'b10; vec_valid = 2'b11;
      #1;
      chk("ab_drop_ready", vec_ready, 2'b00);
      chk("ab_drop_core_en", core_en, 1'b0);
      chk("ab_drop_gnt", gnt, 2'b01);
      chk("ab_drop_rsp_valid", rsp_valid, 1'b0);
      tick();
      req = 2'b00; vec_valid = 2'b00;
      #1;
      chk("ab_rel_gnt", gnt, 2'b00);
      chk("ab_rel_rsp_valid", rsp_valid, 1'b0);
      chk("ab_rel_timeout", timeout, 1'b0);
      chk("ab_rel_count", vec_count, 16'd0);
      tick();
      #1;
      chk("ab_idle_gnt", gnt, 2'b00);
      chk("ab_idle_timeout", timeout, 1'b0);
      tick();

      // Async reset right after a transfer.
      req = 2'b10;
      tick();
      #1 chk("ar_crst_gnt", gnt, 2'b10);
      tick();
      vec_valid = 2'b10; vec1 = 18'h3;
      tick();
      vec_valid = 2'b00;
      #1;
      chk("ar_pre_rsp_valid", rsp_valid, 1'b1);
      chk("ar_pre_count", vec_count, 16'd1);
      chk("ar_pre_gnt", gnt, 2'b10);
      rst = 1'b1;
      #1;
      chk("ar_gnt", gnt, 2'b00);
      chk("ar_rsp_valid", rsp_valid, 1'b0);
      chk("ar_count", vec_count, 16'd0);
      chk("ar_core_rst", core_rst, 1'b1);
      chk("ar_ready", vec_ready, 2'b00);
      chk("ar_rsp_y", rsp_y, 39'd0);
      tick(); tick();
      rst = 1'b0; req = 2'b11;
      #1 chk("ar_idle_gnt", gnt, 2'b00);
      tick();
      #1 chk("ar_first_gnt", gnt, 2'b01);
      req = 2'b00;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fsm_core_arbiter.md
Name: fsm_core_arbiter

Overview:
- Shares one benchmark FSM core (18-bit x input vector, 39-bit Mealy y output vector) between two stimulus requesters.
- Each requester gets an exclusive session. A session opens with a one-cycle core reset, then streams input vectors through a valid/ready handshake and returns one registered response per vector.
- Sits between the test/stimulus masters and the core.
- Arbitration is round-robin. A session closes on a last flag, on a dropped request, or on an idle timeout.

Parameters:
- XW, 18, core input vector width
- YW, 39, core output vector width
- TIMEOUT, 16, idle STREAM cycles with no accepted vector before the session is forcibly closed (must be ≥1)
- CW, 16, width of the session vector counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- req  in  2  session request, one bit per requester (bit i = requester i)
- vec_valid  in  2  vector valid per requester
- vec0  in  XW  requester 0 input vector
- vec1  in  XW  requester 1 input vector
- last  in  2  marks the final vector of a session, qualified by valid&ready
- gnt  out  2  one-hot grant; 0 when idle
- vec_ready  out  2  per-requester ready; only the owner's bit can be 1
- rsp_valid  out  1  response strobe
- rsp_id  out  1  requester the response belongs to
- rsp_y  out  YW  registered core output for the accepted vector
- timeout  out  1  one-cycle pulse when a session is closed by timeout
- vec_count  out  CW  vectors accepted in the current or most recent session, saturating
- core_rst  out  1  core reset
- core_en  out  1  core step enable; the core advances state on the clk edge where core_en=1
- core_x  out  XW  core input vector
- core_y  in  YW  core Mealy output; a combinational function of core state and core_x

Behaviour:
- Reset (rst=1, asynchronous):
  - State=IDLE; gnt=0, vec_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, timeout=0, vec_count=0, core_en=0, core_x=0.
  - last_owner=1, so requester 0 wins first.
  - core_rst=1 for as long as rst=1.
- States: IDLE, CRST, STREAM, REL.
- IDLE:
  - If any req bit is set, choose the owner. If both are set, the owner is the requester that is not last_owner; otherwise it is the single requester.
  - Register the owner and move to CRST.
  - In the same transition: clear vec_count, clear the idle counter, and assert gnt[owner] from the next cycle.
- CRST:
  - Exactly one cycle: core_rst=1, gnt held, vec_ready=0.
  - Next state is STREAM.
- STREAM:
  - vec_ready[owner]=1; the other requester's ready stays 0.
  - A transfer occurs when vec_valid[owner]&vec_ready[owner]. In that cycle:
    - core_x = owner's vector and core_en=1, combinationally.
    - core_y is sampled into rsp_y at the clock edge.
    - rsp_valid=1 and rsp_id=owner in the following cycle.
  - Response latency is 1 cycle. Back-to-back transfers give back-to-back responses.
  - With no transfer: core_x=0, core_en=0.
  - vec_count increments on each transfer and saturates at all-ones.
  - Idle counter:
    - Increments on each STREAM cycle without a transfer; clears on a transfer.
    - When it reaches TIMEOUT-1 with no transfer, go to REL and pulse timeout in the REL cycle.
  - Transfer with last=1: go to REL after the transfer.
  - req[owner]=0 in STREAM: abort. No transfer is accepted that cycle (ready masked), then go to REL. An abort does not set timeout.
  - Priority when several close conditions coincide: abort > last > timeout.
- REL:
  - One cycle: gnt=0, vec_ready=0, core_en=0.
  - last_owner←owner; next state is IDLE.
  - The response from a final transfer still emits in this cycle.
  - The earliest re-grant is the cycle after IDLE, so there is a minimum 1 idle cycle between sessions.
- The non-owner's vec_valid is ignored throughout.
- rsp_valid is never asserted except in the cycle after a transfer.
- rst asserted mid-session: all state clears immediately, the pending response is dropped, and core_rst is asserted.

Test Plan:
- Single session: rst pulse, then req=01 with 3 vectors, the third carrying last. Expect gnt=01 and core_rst=1 in the cycle after the request; vec_ready[0]=1 in the next cycle; 3 rsp_valid pulses with rsp_id=0 one cycle after each transfer; vec_count=3; then REL and gnt=00.
- Round-robin: req=11 held continuously with single-vector sessions. Grant order is 01,10,01,10, with exactly one IDLE cycle plus one CRST cycle between sessions.
- Mealy capture: core model returns y35=y36=1 for x1=x2=1 in its reset state. After CRST, send a vector with bits 0 and 1 set: rsp_y has bits 34 and 35 set, and core_en is 1 only in the transfer cycle.
- Timeout: owner 1 granted and sends 1 vector, then holds vec_valid=0 with TIMEOUT=16. The session closes after 16 idle STREAM cycles, timeout pulses for 1 cycle, vec_count=1, and requester 0 is granted next if it is requesting.
- Abort and foreign valid: owner 0 drops req mid-stream while vec_valid[1]=1. No transfer occurs, there is no response for requester 1, no timeout pulse, and the block goes to REL then IDLE.
- Async reset mid-stream: assert rst between clock edges right after a transfer. gnt, rsp_valid and vec_count go to 0 immediately, core_rst=1, and the next session starts with requester 0.
